// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding and constants for the UART receive controller
package uart_rx_pkg;

  // Frame sequencing states; 3-bit encoding shared by controller and any observers
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    ERR_CHK = 3'd5
  } rx_state_e;

  // Default number of data bits per frame
  localparam int unsigned UART_DATA_W = 8;

  // Supported oversampling ratios
  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // True for states in which the edge and bit counters advance
  function automatic logic is_counting(input rx_state_e s);
    return (s != IDLE) && (s != ERR_CHK);
  endfunction

  // True when the oversampling ratio is one the receiver supports
  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// rtl/uart_rx_ctrl_edge_bit_counter.sv - oversampling edge counter and frame bit counter
module edge_bit_counter #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  localparam logic [PRESCALE_W-1:0] EDGE_ONE = PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  wrap;

  // The last oversampling edge of the current bit
  assign wrap = (edge_cnt_q == (Prescale - EDGE_ONE));

  // Advance edges, roll into the next bit on wrap, clear whenever counting is disabled
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!enable) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (wrap) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + BIT_ONE;
    end else begin
      edge_cnt_d = edge_cnt_q + EDGE_ONE;
    end
  end

  // Counter registers with asynchronous clear
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame sequencer issuing checker, deserializer and valid strobes
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = UART_DATA_W,
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  data_samp_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  deser_en,
  output logic                  data_valid
);

  localparam logic [PRESCALE_W-1:0] EDGE_ONE   = PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0]  FIRST_DATA = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0]  LAST_DATA  = BIT_CNT_W'(DATA_W);

  rx_state_e state_q, state_d;
  logic      bit_end;
  logic      strt_abort;
  logic      stop_done;
  logic      cnt_en;

  assign bit_end = (edge_cnt == (Prescale - EDGE_ONE));

  // The start checker's verdict is consumed on the first edge of the first data bit
  assign strt_abort = (state_q == DATA) && (bit_cnt == FIRST_DATA) &&
                      (edge_cnt == '0) && strt_glitch;

  // The stop bit ends the frame without rolling into another bit
  assign stop_done = (state_q == STOP) && bit_end;

  // Counters run inside a frame and clear on the cycle the frame ends or aborts
  assign cnt_en = is_counting(state_q) && !strt_abort && !stop_done;

  edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_edge_bit_counter (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (cnt_en),
    .Prescale (Prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  // Next-state selection; bit boundaries are taken from the counter's last edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!RX_IN) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA: begin
        if (strt_abort) begin
          state_d = IDLE;
        end else if (bit_end && (bit_cnt == LAST_DATA)) begin
          state_d = PAR_EN ? PARITY : STOP;
        end
      end
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end) state_d = ERR_CHK;
      ERR_CHK: state_d = RX_IN ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any frame in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Oversampling ratio must be a supported value while a frame is being received
  always_ff @(posedge CLK) begin
    if (RST && (state_q != IDLE)) begin
      assert (prescale_legal(int'(Prescale)));
    end
  end

  // Strobes decode the registered state and counters so they hold no combinational input paths,
  // except data_valid which must see the checkers' registered verdicts in ERR_CHK itself
  assign data_samp_en = (state_q != IDLE);
  assign strt_chk_en  = (state_q == START)  && bit_end;
  assign deser_en     = (state_q == DATA)   && bit_end;
  assign par_chk_en   = (state_q == PARITY) && bit_end;
  assign stp_chk_en   = (state_q == STOP)   && bit_end;
  assign data_valid   = (state_q == ERR_CHK) && !stp_err && !(PAR_EN && par_err);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed table-driven bench for the UART receive frame sequencer
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       strt_glitch, par_err, stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       data_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;

  always #5 CLK = ~CLK;

  uart_rx_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .Prescale     (Prescale),
    .strt_glitch  (strt_glitch),
    .par_err      (par_err),
    .stp_err      (stp_err),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .data_samp_en (data_samp_en),
    .strt_chk_en  (strt_chk_en),
    .par_chk_en   (par_chk_en),
    .stp_chk_en   (stp_chk_en),
    .deser_en     (deser_en),
    .data_valid   (data_valid)
  );

  typedef struct {
    int   ps;
    bit   pe;
    logic [7:0] data;
    bit   glitch;
    bit   perr;
    bit   serr;
    bit   pforce;
    bit   b2b;
    int   exp_strt;
    int   exp_deser;
    int   exp_par;
    int   exp_stp;
    int   exp_valid;
    int   exp_valid_at;
  } vec_t;

  vec_t vecs[8];
  int checks = 0;
  int errors = 0;

  // Checker stubs: registered verdicts loaded when the matching enable fires
  bit   stub_clr = 1'b0;
  bit   cur_glitch = 1'b0, cur_perr = 1'b0, cur_serr = 1'b0, cur_pforce = 1'b0;
  logic glitch_q = 1'b0, perr_q = 1'b0, serr_q = 1'b0;

  always @(posedge CLK) begin
    if (stub_clr) begin
      glitch_q <= 1'b0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      if (strt_chk_en) glitch_q <= cur_glitch;
      if (par_chk_en)  perr_q   <= cur_perr;
      if (stp_chk_en)  serr_q   <= cur_serr;
    end
  end

  assign strt_glitch = glitch_q;
  assign par_err     = perr_q | cur_pforce;
  assign stp_err     = serr_q;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Serial line level during cycle t0+n of a frame (n=0 is the IDLE cycle that sees the start bit)
  function automatic logic rx_at(input int n, input vec_t v);
    int fb;
    int span;
    int m;
    int idx;
    fb   = 10 + int'(v.pe);
    span = v.ps * fb + 1;
    m    = n;
    if (v.glitch) return (n < 2) ? 1'b0 : 1'b1;
    if (v.b2b && n >= span) m = n - span;
    if (m == 0) return 1'b0;
    idx = (m - 1) / v.ps;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v.data[idx-1];
    if (idx == 9 && v.pe) return ^v.data;
    return 1'b1;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int fb, span, limit;
    int n_strt, n_deser, n_par, n_stp, n_valid, valid_at, valid_at2, bad, hot;
    string tag;
    tag = $sformatf("v%0d", id);
    fb   = 10 + int'(v.pe);
    span = v.ps * fb + 1;
    limit = (v.b2b ? 2 : 1) * span + 4;
    n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0; n_valid = 0;
    valid_at = 0; valid_at2 = 0; bad = 0;
    @(negedge CLK);
    Prescale   = 6'(v.ps);
    PAR_EN     = v.pe;
    cur_glitch = v.glitch;
    cur_perr   = v.perr;
    cur_serr   = v.serr;
    cur_pforce = v.pforce;
    RX_IN      = 1'b1;
    stub_clr   = 1'b1;
    @(negedge CLK);
    stub_clr = 1'b0;
    RX_IN    = rx_at(0, v);
    for (int n = 1; n <= limit; n++) begin
      @(negedge CLK);
      hot = int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en) + int'(stp_chk_en);
      if (hot > 1) bad++;
      if (strt_chk_en) begin
        n_strt++;
        if (bit_cnt != 4'd0 || int'(edge_cnt) != v.ps - 1) bad++;
      end
      if (deser_en) begin
        n_deser++;
        if (bit_cnt < 4'd1 || bit_cnt > 4'd8 || int'(edge_cnt) != v.ps - 1) bad++;
      end
      if (par_chk_en) begin
        n_par++;
        if (bit_cnt != 4'd9 || int'(edge_cnt) != v.ps - 1) bad++;
      end
      if (stp_chk_en) begin
        n_stp++;
        if (int'(bit_cnt) != 9 + int'(v.pe) || int'(edge_cnt) != v.ps - 1) bad++;
      end
      if (data_valid) begin
        n_valid++;
        if (valid_at == 0) valid_at = n;
        else valid_at2 = n;
      end
      if (v.glitch && n == v.ps + 1) begin
        check({tag, " glitch_data_samp"}, int'(data_samp_en), 1);
        check({tag, " glitch_bit_cnt"},   int'(bit_cnt), 1);
        check({tag, " glitch_edge_cnt"},  int'(edge_cnt), 0);
      end
      if (v.glitch && n == v.ps + 2) begin
        check({tag, " glitch_idle"},      int'(data_samp_en), 0);
        check({tag, " glitch_cnt_clear"}, int'({edge_cnt, bit_cnt}), 0);
      end
      if (v.b2b && n == span + 1) begin
        check({tag, " b2b_start_active"}, int'(data_samp_en), 1);
        check({tag, " b2b_start_edge"},   int'(edge_cnt), 0);
        check({tag, " b2b_start_bit"},    int'(bit_cnt), 0);
      end
      RX_IN = rx_at(n, v);
    end
    check({tag, " strt_chk_count"}, n_strt,   v.exp_strt);
    check({tag, " deser_count"},    n_deser,  v.exp_deser);
    check({tag, " par_chk_count"},  n_par,    v.exp_par);
    check({tag, " stp_chk_count"},  n_stp,    v.exp_stp);
    check({tag, " valid_count"},    n_valid,  v.exp_valid);
    check({tag, " valid_cycle"},    valid_at, v.exp_valid_at);
    check({tag, " strobe_placement"}, bad, 0);
    check({tag, " ends_idle"}, int'(data_samp_en), 0);
    if (v.b2b) check({tag, " b2b_spacing"}, valid_at2 - valid_at, span);
  endtask

  function automatic int all_outs();
    return int'({edge_cnt, bit_cnt, data_samp_en, strt_chk_en, par_chk_en,
                 stp_chk_en, deser_en, data_valid});
  endfunction

  initial begin
    int n_valid;
    vecs[0] = '{8,  0, 8'h55, 0, 0, 0, 0, 0, 1, 8,  0, 1, 1, 81};
    vecs[1] = '{16, 1, 8'hA3, 0, 0, 0, 0, 0, 1, 8,  1, 1, 1, 177};
    vecs[2] = '{8,  0, 8'h55, 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0};
    vecs[3] = '{8,  1, 8'h3C, 0, 0, 1, 0, 0, 1, 8,  1, 1, 0, 0};
    vecs[4] = '{16, 1, 8'h81, 0, 1, 0, 0, 0, 1, 8,  1, 1, 0, 0};
    vecs[5] = '{8,  0, 8'hC6, 0, 0, 0, 1, 0, 1, 8,  0, 1, 1, 81};
    vecs[6] = '{32, 0, 8'h0F, 0, 0, 0, 0, 0, 1, 8,  0, 1, 1, 321};
    vecs[7] = '{8,  1, 8'h5A, 0, 0, 0, 0, 1, 2, 16, 2, 2, 2, 89};

    #1;
    check("reset_outputs", all_outs(), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("post_reset_idle", all_outs(), 0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset during the fourth data bit
    @(negedge CLK);
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    cur_glitch = 1'b0; cur_perr = 1'b0; cur_serr = 1'b0; cur_pforce = 1'b0;
    RX_IN = 1'b1;
    @(negedge CLK);
    RX_IN = rx_at(0, vecs[0]);
    for (int n = 1; n <= 33; n++) begin
      @(negedge CLK);
      RX_IN = rx_at(n, vecs[0]);
    end
    check("midframe_bit_cnt", int'(bit_cnt), 4);
    check("midframe_active", int'(data_samp_en), 1);
    #1 RST = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 0);
    repeat (2) @(negedge CLK);
    RST   = 1'b1;
    RX_IN = 1'b1;
    n_valid = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (data_valid || data_samp_en) n_valid++;
    end
    check("discarded_frame_quiet", n_valid, 0);
    run_vec(8, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Frame-sequencing FSM for the UART receiver. Tracks oversampling edges and bit positions of each incoming frame.
- Pulses the enables for the start, parity and stop checkers, the deserializer and the data sampler at the correct edges.
- Qualifies the received byte with a one-cycle data_valid.
- Sits between the RX_IN pin synchroniser and the RX datapath: data_sampling, strt_check, par_check, stp_check, deserializer.

Parameters:
- DATA_W, 8: data bits per frame.
- PRESCALE_W, 6: width of Prescale and edge_cnt. Oversampling ratio is up to 2^PRESCALE_W-1.
- BIT_CNT_W, 4: width of bit_cnt. Must hold DATA_W+3.

Ports:
- CLK  input  1  RX oversampling clock.
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  synchronised serial line, idle high.
- PAR_EN  input  1  1 means the frame carries a parity bit.
- Prescale  input  PRESCALE_W  oversampling ratio, legal values 8, 16, 32. Stable while not IDLE.
- strt_glitch  input  1  registered result from the start checker.
- par_err  input  1  registered result from the parity checker.
- stp_err  input  1  registered result from the stop checker.
- edge_cnt  output  PRESCALE_W  current oversampling edge, 0..Prescale-1.
- bit_cnt  output  BIT_CNT_W  current bit index within the frame. Start bit is 0.
- data_samp_en  output  1  sampler enable; high in every non-IDLE state.
- strt_chk_en  output  1  one-cycle pulse.
- par_chk_en  output  1  one-cycle pulse.
- stp_chk_en  output  1  one-cycle pulse.
- deser_en  output  1  one-cycle pulse per data bit.
- data_valid  output  1  one-cycle pulse when the frame is good.

Behaviour:
- Reset (async, RST=0):
  - State forced to IDLE; edge_cnt=0, bit_cnt=0.
  - All enables and data_valid are 0 immediately.
  - Reset mid-frame discards the frame; no data_valid is produced.
- Outputs are Moore decodes of the registered state and counters.
- Counters:
  - Counting is active in every state except IDLE and ERR_CHK.
  - edge_cnt increments each cycle and wraps Prescale-1 -> 0.
  - On wrap, bit_cnt increments.
  - In IDLE and ERR_CHK both counters are held at 0.
- "Bit end" means edge_cnt == Prescale-1.
- IDLE:
  - RX_IN==0 -> START on the next edge, entering with edge_cnt=0, bit_cnt=0.
  - RX_IN==1 -> stay.
- START:
  - strt_chk_en=1 at bit end.
  - On wrap -> DATA, with bit_cnt=1.
- DATA:
  - While bit_cnt==1 and edge_cnt==0: if strt_glitch==1 -> IDLE. Counters clear; no check enables or deser_en are issued for this frame.
  - deser_en=1 at bit end.
  - On wrap with bit_cnt==DATA_W -> PARITY if PAR_EN, else STOP.
- PARITY:
  - par_chk_en=1 at bit end.
  - On wrap -> STOP.
- STOP:
  - stp_chk_en=1 at bit end. In that same cycle, next state is ERR_CHK; there is no wrap into another bit.
- ERR_CHK (exactly one cycle):
  - data_valid = !stp_err && !(PAR_EN && par_err).
  - Next state: RX_IN==0 -> START (back-to-back frame), else IDLE.
- Latency:
  - First START cycle is t0+1, where t0 is the IDLE cycle sampling RX_IN=0.
  - data_valid occurs at t0 + 1 + Prescale*(DATA_W+2+PAR_EN).
  - Example, Prescale=8, PAR_EN=1: t0+89.
- Mutual exclusion: at most one of strt_chk_en, par_chk_en, stp_chk_en and deser_en is high in any cycle.
- Error handling: errors never stall the FSM. A bad frame simply yields no data_valid.
- PAR_EN may change only in IDLE; the value used is the one present in DATA and ERR_CHK.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, ERR_CHK, 3-bit encoding;
  - DATA_W default;
  - legal Prescale constants 8, 16, 32.
- One natural sub-module, edge_bit_counter:
  - inputs: CLK, RST, enable, Prescale;
  - outputs: edge_cnt, bit_cnt;
  - counters clear synchronously when enable=0.
- FSM and output decode live in uart_rx_ctrl.

Test Plan:
- Good frame, no parity: Prescale=8, PAR_EN=0, frame 0x55 LSB-first.
  - Exactly 8 deser_en pulses, each at edge_cnt=7.
  - One stp_chk_en.
  - data_valid=1 at t0+81.
- Good frame with parity: Prescale=16, PAR_EN=1, stub errors at 0.
  - par_chk_en once, at bit_cnt=9, edge 15.
  - data_valid at t0+177.
- Start glitch: RX_IN low for 2 cycles; stub drives strt_glitch=1 after strt_chk_en.
  - FSM returns to IDLE at bit_cnt=1, edge 0.
  - No deser_en and no data_valid.
- Stop and parity errors:
  - stp_err=1 in ERR_CHK -> data_valid stays 0, FSM goes to IDLE.
  - par_err=1 with PAR_EN=0 -> data_valid=1.
- Back-to-back frames: RX_IN=0 during ERR_CHK.
  - Next cycle is START with edge_cnt=0.
  - Two data_valid pulses spaced by exactly Prescale*(DATA_W+2+PAR_EN)+1 cycles.
- Reset mid-frame: assert RST=0 during DATA at bit_cnt=4.
  - All outputs go to 0 asynchronously; state is IDLE.
  - After release, a new good frame completes normally.
